// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: schedules note-on/off events onto a bank of voices,
// preferring retrigger, then idle, then the oldest releasing, then the oldest active voice.
module voice_slot #(
    parameter int DATA_WIDTH = 7,
    parameter int AGE_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc,
    input  logic                  rel_req,
    input  logic                  rel_done,
    input  logic                  age_inc,
    input  logic [DATA_WIDTH-1:0] note_in,
    input  logic [DATA_WIDTH-1:0] vel_in,
    output logic                  gate,
    output logic                  busy,
    output logic                  trigger,
    output logic [DATA_WIDTH-1:0] note,
    output logic [DATA_WIDTH-1:0] velocity,
    output logic [AGE_WIDTH-1:0]  age
);
    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASING} vstate_t;
    vstate_t state;

    // Allocation outranks release completion so a stolen releasing voice ends ACTIVE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            note     <= '0;
            velocity <= '0;
            age      <= '0;
            trigger  <= 1'b0;
        end else begin
            trigger <= alloc;
            if (alloc) begin
                state    <= ACTIVE;
                note     <= note_in;
                velocity <= vel_in;
                age      <= '0;
            end else if (rel_done && state == RELEASING) begin
                state <= IDLE;
                age   <= '0;
            end else if (rel_req && state == ACTIVE) begin
                state <= RELEASING;
            end else if (age_inc && state != IDLE && age != '1) begin
                age <= age + AGE_WIDTH'(1);
            end
        end
    end

    assign gate = (state == ACTIVE);
    assign busy = (state != IDLE);
endmodule

module voice_allocator #(
    parameter int VOICES     = 8,
    parameter int DATA_WIDTH = 7,
    parameter int AGE_WIDTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_status,
    input  logic [DATA_WIDTH-1:0]        in_note,
    input  logic [DATA_WIDTH-1:0]        in_velocity,
    input  logic [VOICES-1:0]            release_done,
    output logic [VOICES-1:0]            voice_gate,
    output logic [VOICES-1:0]            voice_busy,
    output logic [VOICES-1:0]            voice_trigger,
    output logic [VOICES*DATA_WIDTH-1:0] voice_note,
    output logic [VOICES*DATA_WIDTH-1:0] voice_velocity
);
    localparam int IW = $clog2(VOICES);

    typedef enum logic {ACCEPT, PROCESS} fsm_t;
    fsm_t fsm;

    logic                  ev_on;
    logic [DATA_WIDTH-1:0] ev_note, ev_vel;

    logic [VOICES-1:0][AGE_WIDTH-1:0]  age;
    logic [VOICES-1:0][DATA_WIDTH-1:0] note_q, vel_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm      <= ACCEPT;
            in_ready <= 1'b1;
            ev_on    <= 1'b0;
            ev_note  <= '0;
            ev_vel   <= '0;
        end else begin
            case (fsm)
                ACCEPT: if (in_valid) begin
                    // velocity-0 note-on is a note-off
                    ev_on    <= in_status && (in_velocity != '0);
                    ev_note  <= in_note;
                    ev_vel   <= in_velocity;
                    fsm      <= PROCESS;
                    in_ready <= 1'b0;
                end
                PROCESS: begin
                    fsm      <= ACCEPT;
                    in_ready <= 1'b1;
                end
                default: begin
                    fsm      <= ACCEPT;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    logic                 hit_f, idle_f, rel_f, act_f, off_f;
    logic [IW-1:0]        hit_i, idle_i, rel_i, act_i, off_i, sel_i;
    logic [AGE_WIDTH-1:0] rel_a, act_a;

    // Ascending scan: first-found keeps lowest index; strict '>' keeps lowest index on age ties.
    always_comb begin
        hit_f = 1'b0; idle_f = 1'b0; rel_f = 1'b0; act_f = 1'b0; off_f = 1'b0;
        hit_i = '0; idle_i = '0; rel_i = '0; act_i = '0; off_i = '0;
        rel_a = '0; act_a = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (!hit_f && voice_busy[i] && note_q[i] == ev_note) begin
                hit_f = 1'b1; hit_i = IW'(i);
            end
            if (!idle_f && !voice_busy[i]) begin
                idle_f = 1'b1; idle_i = IW'(i);
            end
            if (voice_busy[i] && !voice_gate[i] && (!rel_f || age[i] > rel_a)) begin
                rel_f = 1'b1; rel_i = IW'(i); rel_a = age[i];
            end
            if (voice_gate[i] && (!act_f || age[i] > act_a)) begin
                act_f = 1'b1; act_i = IW'(i); act_a = age[i];
            end
            if (!off_f && voice_gate[i] && note_q[i] == ev_note) begin
                off_f = 1'b1; off_i = IW'(i);
            end
        end
        sel_i = hit_f ? hit_i : idle_f ? idle_i : rel_f ? rel_i : act_i;
    end

    logic do_on, do_off;
    assign do_on  = (fsm == PROCESS) && ev_on;
    assign do_off = (fsm == PROCESS) && !ev_on && off_f;

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        voice_slot #(.DATA_WIDTH(DATA_WIDTH), .AGE_WIDTH(AGE_WIDTH)) u_slot (
            .clock    (clock),
            .reset    (reset),
            .alloc    (do_on && sel_i == IW'(g)),
            .rel_req  (do_off && off_i == IW'(g)),
            .rel_done (release_done[g]),
            .age_inc  (do_on),
            .note_in  (ev_note),
            .vel_in   (ev_vel),
            .gate     (voice_gate[g]),
            .busy     (voice_busy[g]),
            .trigger  (voice_trigger[g]),
            .note     (note_q[g]),
            .velocity (vel_q[g]),
            .age      (age[g])
        );
    end

    assign voice_note     = note_q;
    assign voice_velocity = vel_q;
endmodule
